// File: rtl/wvb_rdout_arbiter.sv
// Round-robin scheduler that shares one waveform-buffer readout engine among P_N_CHAN channels.
// It grants a pending channel, starts the engine, and waits for done or a timeout, then holds off.
module wvb_rdout_arbiter #(
    parameter int P_N_CHAN    = 24,
    parameter int P_SEL_WIDTH = 5,
    parameter int P_TIMEOUT   = 4096,
    parameter int P_HOLDOFF   = 2,
    parameter int P_CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arb_en,
    input  logic [P_N_CHAN-1:0]    chan_mask,
    input  logic [P_N_CHAN-1:0]    wvb_avail,
    input  logic                   eng_ready,
    input  logic                   eng_done,
    output logic                   eng_start,
    output logic                   eng_abort,
    output logic [P_SEL_WIDTH-1:0] eng_sel,
    output logic                   busy,
    output logic                   err_timeout,
    output logic [P_CNT_WIDTH-1:0] grant_cnt
);
    localparam int TW = $clog2(P_TIMEOUT);
    localparam int HW = $clog2(P_HOLDOFF + 1);
    localparam logic [P_SEL_WIDTH:0]   L_N    = (P_SEL_WIDTH+1)'(P_N_CHAN);
    localparam logic [P_SEL_WIDTH-1:0] L_LAST = P_SEL_WIDTH'(P_N_CHAN - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARB     = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    logic                   rst_q;
    logic                   srst;
    logic [2:0]             state_q, state_d;
    logic [P_N_CHAN-1:0]    req_q, req_d;
    logic [P_SEL_WIDTH-1:0] sel_q, sel_d;
    logic [P_SEL_WIDTH-1:0] last_q, last_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [HW-1:0]          ho_q, ho_d;
    logic                   start_q, start_d;
    logic                   abort_q, abort_d;
    logic                   err_q, err_d;
    logic [P_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [P_N_CHAN-1:0]    elig;

    // The raw reset acts at once; the registered copy stretches it by one cycle on release.
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end
    assign srst = rst | rst_q;

    assign elig = wvb_avail & chan_mask;

    // Rotate requests so the channel after last_grant sits at bit 0, then take the lowest set bit.
    logic [P_SEL_WIDTH-1:0]     rot_base;
    logic [2*P_N_CHAN-1:0]      req2;
    logic [P_N_CHAN-1:0]        rot;
    logic [P_N_CHAN-1:0]        below;
    logic [P_N_CHAN-1:0]        first_oh;
    logic [P_SEL_WIDTH-1:0]     enc_acc [0:P_N_CHAN];
    logic [P_SEL_WIDTH:0]       pick_sum;
    logic [P_SEL_WIDTH-1:0]     pick;

    assign rot_base   = (last_q == L_LAST) ? '0 : last_q + P_SEL_WIDTH'(1);
    assign req2       = {req_q, req_q};
    assign rot        = P_N_CHAN'(req2 >> rot_base);
    assign enc_acc[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < P_N_CHAN; gi++) begin : g_pick
            if (gi == 0) begin : g_first
                assign below[gi] = 1'b0;
            end else begin : g_rest
                assign below[gi] = below[gi-1] | rot[gi-1];
            end
            assign first_oh[gi]  = rot[gi] & ~below[gi];
            assign enc_acc[gi+1] = enc_acc[gi] | (first_oh[gi] ? P_SEL_WIDTH'(gi) : '0);
        end
    endgenerate

    assign pick_sum = {1'b0, rot_base} + {1'b0, enc_acc[P_N_CHAN]};
    assign pick     = (pick_sum >= L_N) ? P_SEL_WIDTH'(pick_sum - L_N) : P_SEL_WIDTH'(pick_sum);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        sel_d   = sel_q;
        last_d  = last_q;
        tmo_d   = tmo_q;
        ho_d    = ho_q;
        start_d = 1'b0;
        abort_d = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (arb_en && eng_ready && (|elig)) begin
                    req_d   = elig;
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                sel_d   = pick;
                start_d = 1'b1;
                state_d = S_START;
            end
            S_START: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tmo_d = tmo_q + TW'(1);
                // Done takes priority over a timeout landing in the same cycle.
                if (eng_done) begin
                    last_d  = sel_q;
                    cnt_d   = cnt_q + P_CNT_WIDTH'(1);
                    ho_d    = '0;
                    state_d = S_HOLDOFF;
                end else if (tmo_q == TW'(P_TIMEOUT - 1)) begin
                    abort_d = 1'b1;
                    err_d   = 1'b1;
                    last_d  = sel_q;
                    ho_d    = '0;
                    state_d = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (ho_q == HW'(P_HOLDOFF - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    ho_d = ho_q + HW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            sel_q   <= '0;
            last_q  <= L_LAST;
            tmo_q   <= '0;
            ho_q    <= '0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
            ho_q    <= ho_d;
            start_q <= start_d;
            abort_q <= abort_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign eng_start   = start_q;
    assign eng_abort   = abort_q;
    assign eng_sel     = sel_q;
    assign busy        = (state_q != S_IDLE);
    assign err_timeout = err_q;
    assign grant_cnt   = cnt_q;

endmodule

// File: tb/tb_wvb_rdout_arbiter.sv
// Bench for wvb_rdout_arbiter: expected grants go into a queue checked by a start monitor,
// while timing, timeout, and reset behaviour are checked directly in the stimulus.
module tb_wvb_rdout_arbiter;
    localparam int N  = 24;
    localparam int SW = 5;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arb_en = 1'b1;
    logic [N-1:0]  chan_mask = '1;
    logic [N-1:0]  wvb_avail = '0;
    logic          eng_ready = 1'b1;
    logic          eng_done = 1'b0;
    logic          eng_start;
    logic          eng_abort;
    logic [SW-1:0] eng_sel;
    logic          busy;
    logic          err_timeout;
    logic [CW-1:0] grant_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int exp_q[$];

    wvb_rdout_arbiter #(
        .P_N_CHAN(N), .P_SEL_WIDTH(SW), .P_TIMEOUT(16), .P_HOLDOFF(2), .P_CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .arb_en(arb_en), .chan_mask(chan_mask), .wvb_avail(wvb_avail),
        .eng_ready(eng_ready), .eng_done(eng_done), .eng_start(eng_start), .eng_abort(eng_abort),
        .eng_sel(eng_sel), .busy(busy), .err_timeout(err_timeout), .grant_cnt(grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        chk_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    // Scoreboard monitor: each engine start must match the next queued grant.
    always @(negedge clk) begin
        if (eng_start === 1'b1) begin
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL grant_sel: got sel %0d, want no grant", eng_sel);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(eng_sel) == e) begin
                    pass_cnt++;
                    $display("grant sel=%0d t=%0t", eng_sel, $time);
                end else begin
                    $display("FAIL grant_sel: got %0d, want %0d", eng_sel, e);
                end
            end
        end
    end

    task automatic wait_start();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (eng_start === 1'b1) ok = 1'b1;
        end
        check("start_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic pulse_done();
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
    endtask

    task automatic do_grant(input int delay);
        wait_start();
        repeat (delay) @(negedge clk);
        pulse_done();
    endtask

    task automatic do_reset();
        wvb_avail = '0;
        eng_done  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit saw_abort;
        // 1: reset state, latency, single grant on ch3, hold-off
        do_reset();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_start", {31'd0, eng_start}, 32'd0);
        check("rst_sel", {27'd0, eng_sel}, 32'd0);
        check("rst_err", {31'd0, err_timeout}, 32'd0);
        check("rst_cnt", grant_cnt, 32'd0);
        exp_q.push_back(3);
        wvb_avail = 24'h000008;
        @(negedge clk);
        check("lat_n1_start", {31'd0, eng_start}, 32'd0);
        @(negedge clk);
        check("lat_n2_start", {31'd0, eng_start}, 32'd1);
        wvb_avail = '0;
        repeat (3) @(negedge clk);
        pulse_done();
        check("t1_cnt", grant_cnt, 32'd1);
        check("t1_busy_h0", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("t1_busy_h1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("t1_idle", {31'd0, busy}, 32'd0);

        // 2: round robin over ch0, ch5, ch23
        do_reset();
        exp_q.push_back(0); exp_q.push_back(5); exp_q.push_back(23);
        exp_q.push_back(0); exp_q.push_back(5);
        wvb_avail = 24'h800021;
        for (int g = 0; g < 5; g++) do_grant(10);
        wvb_avail = '0;
        check("t2_cnt", grant_cnt, 32'd5);

        // 3: only the unmasked channel is granted
        do_reset();
        chan_mask = 24'h000002;
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
        wvb_avail = '1;
        for (int g = 0; g < 3; g++) do_grant(2);
        wvb_avail = '0;
        chan_mask = '1;
        check("t3_cnt", grant_cnt, 32'd3);

        // 5: done and timeout in the same cycle -> done wins
        do_reset();
        exp_q.push_back(2);
        wvb_avail = 24'h000004;
        wait_start();
        wvb_avail = '0;
        saw_abort = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 17) eng_done = 1'b0;
            if (eng_abort === 1'b1) saw_abort = 1'b1;
            if (k == 16) eng_done = 1'b1;
        end
        check("t5_no_abort", {31'd0, saw_abort}, 32'd0);
        check("t5_err", {31'd0, err_timeout}, 32'd0);
        check("t5_cnt", grant_cnt, 32'd1);

        // 4: timeout on ch7, then next grant goes to ch8
        repeat (3) @(negedge clk);
        exp_q.push_back(7);
        wvb_avail = 24'h000080;
        wait_start();
        wvb_avail = 24'h000180;
        saw_abort = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (eng_abort === 1'b1) saw_abort = 1'b1;
        end
        check("t4_early_abort", {31'd0, saw_abort}, 32'd0);
        check("t4_err_before", {31'd0, err_timeout}, 32'd0);
        exp_q.push_back(8);
        @(negedge clk);
        check("t4_abort", {31'd0, eng_abort}, 32'd1);
        check("t4_err", {31'd0, err_timeout}, 32'd1);
        check("t4_cnt_same", grant_cnt, 32'd1);
        @(negedge clk);
        check("t4_abort_pulse", {31'd0, eng_abort}, 32'd0);
        do_grant(3);
        wvb_avail = '0;
        check("t4_err_sticky", {31'd0, err_timeout}, 32'd1);
        check("t4_cnt_after", grant_cnt, 32'd2);

        // 6: reset during S_WAIT, then ch0 has priority again
        repeat (3) @(negedge clk);
        exp_q.push_back(4);
        wvb_avail = 24'h000010;
        wait_start();
        wvb_avail = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_start", {31'd0, eng_start}, 32'd0);
        check("t6_abort", {31'd0, eng_abort}, 32'd0);
        check("t6_sel", {27'd0, eng_sel}, 32'd0);
        check("t6_err", {31'd0, err_timeout}, 32'd0);
        check("t6_cnt", grant_cnt, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.push_back(0);
        wvb_avail = 24'h000011;
        do_grant(2);
        wvb_avail = '0;
        check("t6_cnt_after", grant_cnt, 32'd1);

        repeat (8) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
